// File: rtl/uart_cmd_parser_if.sv
// ============================================================================
//  Module      : uart_cmd_parser_if
//  Description : Bundles the UART byte input and the decoded command outputs
//                of the command parser. The slave side is the parser itself;
//                the master side is whatever feeds bytes and consumes commands.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cmd_parser_if;

    // Byte side, produced by the UART receiver (slow, asynchronous)
    logic        Rx_ACK;
    logic [7:0]  Rx_Data;

    // Command side, produced by the parser in the clk_100MHz domain
    logic        Cmd_Valid;
    logic [7:0]  Cmd_Code;
    logic [15:0] Cmd_Arg;
    logic        Frame_Err;
    logic        Busy;

    modport master (
        output Rx_ACK,
        output Rx_Data,
        input  Cmd_Valid,
        input  Cmd_Code,
        input  Cmd_Arg,
        input  Frame_Err,
        input  Busy
    );

    modport slave (
        input  Rx_ACK,
        input  Rx_Data,
        output Cmd_Valid,
        output Cmd_Code,
        output Cmd_Arg,
        output Frame_Err,
        output Busy
    );

endinterface

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
//  Module      : uart_cmd_parser
//  Description : Synchronises the UART byte strobe into clk_100MHz, assembles
//                5-byte frames (HEADER, CMD, ARG_H, ARG_L, CHK), checks the
//                XOR checksum, enforces an inter-byte timeout and emits one
//                command/argument pair per good frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
    parameter logic [7:0]  HEADER         = 8'hAA,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  wire logic        clk_100MHz,
    input  wire logic        Rst,
    uart_cmd_parser_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    // Value the counter holds one cycle before it would reach CNT_MAX; the
    // timeout is acted on in that cycle so Frame_Err lands on the same edge
    // that the counter would have hit the limit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GET_CMD = 3'd1;
    localparam logic [2:0] GET_AH  = 3'd2;
    localparam logic [2:0] GET_AL  = 3'd3;
    localparam logic [2:0] GET_CHK = 3'd4;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic             ack_sync1;
    logic             ack_sync2;
    logic             ack_sync3;
    logic             ack_rise;
    logic             byte_stb;
    logic [7:0]       byte_r;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             busy;

    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout;

    logic [7:0]       cmd_t;
    logic [7:0]       ah_t;
    logic [7:0]       al_t;
    logic [7:0]       chk_calc;

    logic             cmd_valid_next;
    logic             frame_err_next;
    logic             cmd_valid;
    logic             frame_err;
    logic [7:0]       cmd_code;
    logic [15:0]      cmd_arg;

    // ------------------------------------------------------------------------
    // Byte strobe generation
    // ------------------------------------------------------------------------
    // A held-high Rx_ACK yields a single rise, so one byte gives one strobe.
    assign ack_rise = ack_sync2 & ~ack_sync3;

    // Two-flop synchroniser, edge register, and registered strobe/data capture
    always_ff @(posedge clk_100MHz) begin
        if (Rst) begin
            ack_sync1 <= 1'b0;
            ack_sync2 <= 1'b0;
            ack_sync3 <= 1'b0;
            byte_stb  <= 1'b0;
            byte_r    <= 8'h00;
        end else begin
            ack_sync1 <= bus.Rx_ACK;
            ack_sync2 <= ack_sync1;
            ack_sync3 <= ack_sync2;
            byte_stb  <= ack_rise;
            // Rx_Data is stable while Rx_ACK is high, which covers the rise
            if (ack_rise) begin
                byte_r <= bus.Rx_Data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    assign chk_calc = cmd_t ^ ah_t ^ al_t;

    // A byte arriving in the same cycle as the limit takes priority.
    assign timeout = (state != IDLE) && !byte_stb && (tmo_cnt == CNT_LAST);

    // State register; Busy is registered alongside so it tracks the state
    always_ff @(posedge clk_100MHz) begin
        if (Rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Next-state: advance only on a byte strobe or on timeout
    always_comb begin
        state_next = state;
        if (byte_stb) begin
            case (state)
                IDLE:    state_next = (byte_r == HEADER) ? GET_CMD : IDLE;
                GET_CMD: state_next = GET_AH;
                GET_AH:  state_next = GET_AL;
                GET_AL:  state_next = GET_CHK;
                GET_CHK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            state_next = IDLE;
        end
    end

    // Output decode: result pulses for a completed frame or an expired gap
    always_comb begin
        cmd_valid_next = 1'b0;
        frame_err_next = 1'b0;
        if (byte_stb && (state == GET_CHK)) begin
            if (byte_r == chk_calc) begin
                cmd_valid_next = 1'b1;
            end else begin
                frame_err_next = 1'b1;
            end
        end else if (timeout) begin
            frame_err_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // Inter-byte timer: idle and every byte restart it, it saturates at limit
    always_ff @(posedge clk_100MHz) begin
        if (Rst) begin
            tmo_cnt <= '0;
        end else if (byte_stb || (state == IDLE) || timeout) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Frame temporaries: captured byte by byte, dropped on timeout
    always_ff @(posedge clk_100MHz) begin
        if (Rst || timeout) begin
            cmd_t <= 8'h00;
            ah_t  <= 8'h00;
            al_t  <= 8'h00;
        end else if (byte_stb) begin
            case (state)
                GET_CMD: cmd_t <= byte_r;
                GET_AH:  ah_t  <= byte_r;
                GET_AL:  al_t  <= byte_r;
                default: ;
            endcase
        end
    end

    // Output registers: pulses every cycle, command fields only on good frame
    always_ff @(posedge clk_100MHz) begin
        if (Rst) begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            cmd_code  <= 8'h00;
            cmd_arg   <= 16'h0000;
        end else begin
            cmd_valid <= cmd_valid_next;
            frame_err <= frame_err_next;
            if (cmd_valid_next) begin
                cmd_code <= cmd_t;
                cmd_arg  <= {ah_t, al_t};
            end
        end
    end

    assign bus.Cmd_Valid = cmd_valid;
    assign bus.Cmd_Code  = cmd_code;
    assign bus.Cmd_Arg   = cmd_arg;
    assign bus.Frame_Err = frame_err;
    assign bus.Busy      = busy;

endmodule

`default_nettype wire
